// File: rtl/stump_uart_tx.sv
// stump_uart_tx: memory-mapped 8N1 serial transmitter on the Stump data bus.
// TXDATA at BASE_ADDR pushes a byte into a small FIFO; STATUS at BASE_ADDR+1
// reports FIFO/transmitter state and clears the sticky overflow flag.
module stump_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          FIFO_DEPTH = 4,
  parameter int          BAUD_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        mem_wen,
  input  logic        mem_ren,
  output logic [15:0] rd_data,
  output logic        hit,
  output logic        txd,
  output logic        tx_busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nx;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [BW-1:0]   baud_cnt, cnt_nx;
  logic [2:0]      bit_idx, idx_nx;
  logic [7:0]      shifter, sh_nx;
  logic            txd_q, txd_nx;
  logic            pop;

  // Bus decode
  logic sel_data, sel_stat, full, empty, push, accept, ovf_set, ovf_clr, cnt_end;
  assign sel_data = (address == BASE_ADDR);
  assign sel_stat = (address == BASE_ADDR + 16'd1);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = mem_wen && sel_data;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands
  assign accept   = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign ovf_clr  = mem_wen && sel_stat && data_out[3];
  assign cnt_end  = (baud_cnt == BW'(BAUD_DIV - 1));

  assign hit     = (mem_ren || mem_wen) && (sel_data || sel_stat);
  assign rd_data = (mem_ren && sel_stat) ?
                   {8'h00, 4'(count), overflow, (state != IDLE), empty, full} : 16'h0000;
  assign txd     = txd_q;
  assign tx_busy = (state != IDLE) || !empty;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_out[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      if (accept && !pop)      count <= count + CW'(1);
      else if (!accept && pop) count <= count - CW'(1);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // FSM state register and serial datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= cnt_nx;
      bit_idx  <= idx_nx;
      shifter  <= sh_nx;
      txd_q    <= txd_nx;
    end
  end

  // Next-state, pop and next txd; txd is loaded only on slot boundaries
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    txd_nx   = txd_q;
    idx_nx   = bit_idx;
    sh_nx    = shifter;
    cnt_nx   = (state == IDLE || cnt_end) ? '0 : baud_cnt + BW'(1);
    case (state)
      IDLE: begin
        txd_nx = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          sh_nx    = mem[rd_ptr];
          state_nx = START;
          txd_nx   = 1'b0;
        end
      end
      START: if (cnt_end) begin
        state_nx = DATA;
        idx_nx   = 3'd0;
        txd_nx   = shifter[0];
      end
      DATA: if (cnt_end) begin
        sh_nx  = {1'b0, shifter[7:1]};
        idx_nx = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          state_nx = STOP;
          txd_nx   = 1'b1;
        end else begin
          txd_nx = shifter[1];
        end
      end
      STOP: if (cnt_end) begin
        // Back-to-back frames: reload straight into START with no idle slot
        if (!empty) begin
          pop      = 1'b1;
          sh_nx    = mem[rd_ptr];
          state_nx = START;
          txd_nx   = 1'b0;
        end else begin
          state_nx = IDLE;
          txd_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
